router_pkt_reg: RTL and testbench
=================================

# router_pkt_reg

Parametrised packet register stage for the router datapath. Sits between the source byte stream and the per-channel output FIFOs, with its own packet FSM. It decodes the header, routes header, payload and check words to one of NUM_CH FIFOs through a one-word hold register when the target is full, and checks the packet with XOR parity or CRC. It also checks the payload length against the header and reports per-packet status plus a saturating error count.

## Interface
- DATA_W, 8: word width (≥4).
- NUM_CH, 3: number of output channels/FIFOs (2..16). ADDR_W = max(1, clog2(NUM_CH)); LEN_W = DATA_W−ADDR_W.
- CHK_MODE, 0: 0 = XOR parity, 1 = CRC.
- CRC_POLY, 8'h07: CRC polynomial (DATA_W bits, implicit top bit), used when CHK_MODE=1.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pkt_valid  in  1  high for header and payload words; low on the check word.
- data_in  in  DATA_W  source word.
- fifo_full  in  NUM_CH  full flag per output FIFO.
- busy  out  1  registered; source holds data_in/pkt_valid while high.
- dout  out  DATA_W  word to FIFOs.
- fifo_we  out  NUM_CH  one-hot write enable, qualifies dout.
- pkt_done  out  1  one-cycle pulse at packet check.
- parity_err  out  1  valid with pkt_done.
- len_err  out  1  valid with pkt_done.
- addr_err  out  1  one-cycle pulse on invalid destination.
- err_count  out  16  saturating count of packets with any error.

## Operation
- Header: addr = data_in[ADDR_W−1:0], len = data_in[DATA_W−1:ADDR_W].
- A word is accepted in a cycle where busy=0 and the FSM is IDLE with pkt_valid=1, or in LOAD/DROP. All other inputs are ignored.
- States:
  - IDLE: an accepted header latches ch = addr.
    - addr ≥ NUM_CH → DROP, pulse addr_err.
    - Otherwise → LOAD, clear accumulator, fold header into it.
  - LOAD: an accepted word with pkt_valid=1 is payload. It is folded into the accumulator and increments pay_cnt, which saturates at 2^LEN_W−1 plus an overflow flag. An accepted word with pkt_valid=0 is the check word: it is latched as rx_chk and the FSM goes → CHECK.
  - CHECK: one cycle. pkt_done=1.
    - parity_err = (acc ≠ rx_chk).
    - len_err = (pay_cnt ≠ len) or overflow.
    - err_count increments (saturating at 16'hFFFF) if either is set.
    - Then → IDLE.
  - DROP: nothing is written and there is no pkt_done. The FSM consumes words until one is accepted with pkt_valid=0, then → IDLE. err_count increments at addr_err.
- Accumulator:
  - XOR mode: acc ^= word.
  - CRC mode: MSB-first, init 0, DATA_W bits per word, no reflection or final XOR.
- Writes (LOAD path, including the check word):
  - Accepted word with !fifo_full[ch] → next cycle dout=word, fifo_we[ch]=1.
  - Accepted word with fifo_full[ch] → captured in the hold register (hold_valid=1).
  - While hold_valid: the first cycle with !fifo_full[ch] writes the hold word next cycle and clears hold_valid.
- Busy: busy_next = hold_valid_next | (state_next==CHECK). Word order into the FIFO always equals arrival order.

## Timing
- Reset values: busy, fifo_we, pkt_done, parity_err, len_err, addr_err = 0; dout = 0; err_count = 0; state IDLE; hold_valid = 0; accumulator, pay_cnt and ch = 0.
- Write latency: 1 cycle from acceptance (direct path), or 1 cycle from fifo_full deasserting (hold path).
- Check word accepted at cycle t → pkt_done, parity_err and len_err high at t+1 only. busy=1 at t+1, so the earliest next header is accepted at t+2.
- addr_err is high the cycle after the bad header is accepted.
- Header accepted while fifo_full[ch]=1: the header goes to hold and busy=1 the next cycle.
- fifo_full toggling on a channel other than ch has no effect.
- Reset mid-packet: the packet is abandoned, the hold word is discarded and there is no pkt_done.
- Errors are never reported for a dropped packet beyond addr_err.

## Structure
- Shared package router_pkg:
  - FSM state enum (IDLE, LOAD, CHECK, DROP)
  - CHK_XOR/CHK_CRC constants
  - ADDR_W/LEN_W derivation function
- Sub-module router_chk_acc: holds the accumulator register, with clear, fold-enable and word inputs, parametrised by DATA_W/CHK_MODE/CRC_POLY, and contains the CRC step function.
- The FSM, hold register, counters and write steering live in router_pkt_reg.

## Test plan
All cases use DATA_W=8, NUM_CH=3 and XOR unless noted.
- Good packet: header 8'h0D (len 3, ch 1), payload 11, 22, 33, check 8'h0D → fifo_we=3'b010 for 5 words in order, pkt_done=1, no errors, err_count=0.
- Bad parity: same packet with check 8'h0C → parity_err=1 with pkt_done, err_count=1.
- Backpressure: fifo_full[1] high for 3 cycles starting at acceptance of 22 → 22 held, busy=1, source holds 33; after release FIFO sees 0D, 11, 22, 33, 0D with no loss or duplicate.
- Invalid address: header 8'h07 (ch 3) → addr_err pulse, no fifo_we, payload/check consumed; the following good packet completes normally; err_count=1.
- Length/CRC: header 8'h09 (len 2) with 3 payload words → len_err=1. With CHK_MODE=1 and a correct CRC-8/0x07 check word → parity_err=0.
- Reset mid-payload → all outputs 0 within the reset cycle, state IDLE; the next packet passes cleanly.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared types, constants and width helpers for the router packet stage.
package router_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DROP  = 2'd3
   } state_t;

   localparam int CHK_XOR = 0;
   localparam int CHK_CRC = 1;

   // Address field is at least one bit wide so a 2-channel router still decodes
   function automatic int calc_addr_w(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   // The rest of the header word carries the payload length
   function automatic int calc_len_w(input int data_w, input int num_ch);
      return data_w - calc_addr_w(num_ch);
   endfunction

endpackage

// File: rtl/router_chk_acc.sv
// router_chk_acc: running packet check accumulator, either XOR parity or MSB-first CRC.
module router_chk_acc
   import router_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                CHK_MODE = CHK_XOR,
   parameter logic [DATA_W-1:0] CRC_POLY = 8'h07
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              fold,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] acc
);

   logic [DATA_W-1:0] base;
   logic [DATA_W-1:0] folded;

   // One word through the CRC shift register, most significant data bit first
   function automatic logic [DATA_W-1:0] crc_step(input logic [DATA_W-1:0] crc_in,
                                                  input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] c;
      logic              fb;
      c = crc_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = c[DATA_W-1] ^ w[i];
         c  = {c[DATA_W-2:0], 1'b0};
         if (fb) begin
            c = c ^ CRC_POLY;
         end
      end
      return c;
   endfunction

   // A clear restarts from zero so the header can be folded in the same cycle
   always_comb begin
      base   = clear ? '0 : acc;
      folded = (CHK_MODE == CHK_CRC) ? crc_step(base, word) : (base ^ word);
   end

   // Accumulator register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (fold) begin
         acc <= folded;
      end else if (clear) begin
         acc <= '0;
      end
   end

endmodule

// File: rtl/router_pkt_reg.sv
// router_pkt_reg: packet register stage steering header, payload and check words
// into one of NUM_CH output FIFOs through a single-word hold register, with
// packet check, length check and a saturating error counter.
module router_pkt_reg
   import router_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                NUM_CH   = 3,
   parameter int                CHK_MODE = CHK_XOR,
   parameter logic [DATA_W-1:0] CRC_POLY = 8'h07
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0] fifo_full,
   output logic              busy,
   output logic [DATA_W-1:0] dout,
   output logic [NUM_CH-1:0] fifo_we,
   output logic              pkt_done,
   output logic              parity_err,
   output logic              len_err,
   output logic              addr_err,
   output logic [15:0]       err_count
);

   localparam int                ADDR_W   = calc_addr_w(NUM_CH);
   localparam int                LEN_W    = calc_len_w(DATA_W, NUM_CH);
   localparam int                CMP_W    = ADDR_W + 1;
   localparam logic [CMP_W-1:0]  CH_LIMIT = CMP_W'(NUM_CH);
   localparam logic [LEN_W-1:0]  LEN_MAX  = '1;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] ch;
   logic [ADDR_W-1:0] hdr_addr;
   logic [ADDR_W-1:0] wr_ch;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  hdr_len;
   logic [LEN_W-1:0]  pay_cnt;
   logic              pay_ovf;
   logic              hold_valid;
   logic              hold_valid_next;
   logic              hold_load;
   logic [DATA_W-1:0] hold_word;
   logic [DATA_W-1:0] wr_word;
   logic [DATA_W-1:0] acc;
   logic              accept;
   logic              hdr_ok;
   logic              hdr_full;
   logic              ch_full;
   logic              acc_clear;
   logic              acc_fold;
   logic              wr_path;
   logic              wr_full;
   logic              wr_en;
   logic              chk_bad;
   logic              cnt_bad;
   logic [NUM_CH-1:0] we_next;

   assign hdr_addr  = data_in[ADDR_W-1:0];
   assign hdr_len   = data_in[DATA_W-1:ADDR_W];
   assign hdr_ok    = {1'b0, hdr_addr} < CH_LIMIT;
   assign accept    = ~busy & (((state == IDLE) & pkt_valid) | (state == LOAD) | (state == DROP));
   assign chk_bad   = (acc != data_in);
   assign cnt_bad   = (pay_cnt != len) | pay_ovf;
   assign acc_clear = accept & (state == IDLE) & hdr_ok;
   assign acc_fold  = acc_clear | (accept & (state == LOAD) & pkt_valid);

   router_chk_acc #(
      .DATA_W   (DATA_W),
      .CHK_MODE (CHK_MODE),
      .CRC_POLY (CRC_POLY)
   ) u_chk_acc (
      .clock (clock),
      .reset (reset),
      .clear (acc_clear),
      .fold  (acc_fold),
      .word  (data_in),
      .acc   (acc)
   );

   // Full flag of the channel addressed by an incoming header and of the latched channel
   always_comb begin
      hdr_full = 1'b0;
      ch_full  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (hdr_addr == ADDR_W'(i)) begin
            hdr_full = fifo_full[i];
         end
         if (ch == ADDR_W'(i)) begin
            ch_full = fifo_full[i];
         end
      end
   end

   // Next state and write steering; a pending hold word always drains before a new word is taken
   always_comb begin
      state_next      = state;
      hold_valid_next = hold_valid;
      hold_load       = 1'b0;
      wr_en           = 1'b0;
      wr_word         = data_in;
      wr_ch           = ch;
      wr_path         = accept & (((state == IDLE) & hdr_ok) | (state == LOAD));
      wr_full         = (state == IDLE) ? hdr_full : ch_full;
      case (state)
         IDLE:    if (accept) state_next = hdr_ok ? LOAD : DROP;
         LOAD:    if (accept && !pkt_valid) state_next = CHECK;
         CHECK:   state_next = IDLE;
         DROP:    if (accept && !pkt_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (hold_valid) begin
         if (!ch_full) begin
            wr_en           = 1'b1;
            wr_word         = hold_word;
            hold_valid_next = 1'b0;
         end
      end else if (wr_path) begin
         if (state == IDLE) begin
            wr_ch = hdr_addr;
         end
         if (wr_full) begin
            hold_valid_next = 1'b1;
            hold_load       = 1'b1;
         end else begin
            wr_en = 1'b1;
         end
      end
   end

   // One-hot FIFO write enable for the selected channel
   always_comb begin
      we_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         we_next[i] = wr_en && (wr_ch == ADDR_W'(i));
      end
   end

   // Packet FSM, hold register, payload counter and all registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ch         <= '0;
         len        <= '0;
         pay_cnt    <= '0;
         pay_ovf    <= 1'b0;
         hold_valid <= 1'b0;
         hold_word  <= '0;
         busy       <= 1'b0;
         dout       <= '0;
         fifo_we    <= '0;
         pkt_done   <= 1'b0;
         parity_err <= 1'b0;
         len_err    <= 1'b0;
         addr_err   <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_next;
         hold_valid <= hold_valid_next;
         busy       <= hold_valid_next | (state_next == CHECK);
         fifo_we    <= we_next;
         pkt_done   <= 1'b0;
         parity_err <= 1'b0;
         len_err    <= 1'b0;
         addr_err   <= 1'b0;
         if (hold_load) begin
            hold_word <= data_in;
         end
         if (wr_en) begin
            dout <= wr_word;
         end
         if (accept) begin
            case (state)
               IDLE: begin
                  ch <= hdr_addr;
                  if (hdr_ok) begin
                     len     <= hdr_len;
                     pay_cnt <= '0;
                     pay_ovf <= 1'b0;
                  end else begin
                     addr_err <= 1'b1;
                     if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                     end
                  end
               end
               LOAD: begin
                  if (pkt_valid) begin
                     if (pay_cnt == LEN_MAX) begin
                        pay_ovf <= 1'b1;
                     end else begin
                        pay_cnt <= pay_cnt + LEN_W'(1);
                     end
                  end else begin
                     pkt_done   <= 1'b1;
                     parity_err <= chk_bad;
                     len_err    <= cnt_bad;
                     if ((chk_bad || cnt_bad) && (err_count != 16'hFFFF)) begin
                        err_count <= err_count + 16'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_reg.sv
// tb_router_pkt_reg: drives an XOR instance and a CRC instance with the same
// source stream and FIFO backpressure, and checks both against a packet-level model.
module tb_router_pkt_reg;

   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] data;
   } wr_t;

   typedef struct packed {
      logic xperr;
      logic cperr;
      logic lerr;
   } stat_t;

   logic        clock;
   logic        reset;
   logic        pkt_valid;
   logic [7:0]  data_in;
   logic        fullRandom;
   logic [2:0]  randFull;
   logic [2:0]  forcedFull;
   wire  [2:0]  fifo_full = fullRandom ? randFull : forcedFull;

   logic        busyX, busyC;
   logic [7:0]  doutX, doutC;
   logic [2:0]  weX, weC;
   logic        doneX, doneC;
   logic        perrX, perrC;
   logic        lerrX, lerrC;
   logic        aerrX, aerrC;
   logic [15:0] errCntX, errCntC;

   int          checks;
   int          errors;
   int          addrErrSent;
   int          addrErrSeen;
   int          expErrX;
   int          expErrC;
   wr_t         expWr[$];
   stat_t       statQ[$];
   logic [7:0]  pay[$];
   wr_t         mw;
   stat_t       ms;

   router_pkt_reg #(.DATA_W(8), .NUM_CH(3), .CHK_MODE(0), .CRC_POLY(8'h07)) dutXor (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .busy(busyX), .dout(doutX), .fifo_we(weX),
      .pkt_done(doneX), .parity_err(perrX), .len_err(lerrX), .addr_err(aerrX),
      .err_count(errCntX)
   );

   router_pkt_reg #(.DATA_W(8), .NUM_CH(3), .CHK_MODE(1), .CRC_POLY(8'h07)) dutCrc (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .busy(busyC), .dout(doutC), .fifo_we(weC),
      .pkt_done(doneC), .parity_err(perrC), .len_err(lerrC), .addr_err(aerrC),
      .err_count(errCntC)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Random backpressure: each FIFO reports full about a quarter of the time
   always @(posedge clock) begin
      randFull <= {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Standard table-less CRC-8 over one byte: xor in, then eight polynomial divisions
   function automatic logic [7:0] crcByte(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] c;
      c = crc ^ b;
      for (int k = 0; k < 8; k++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic expectWord(input logic [1:0] c, input logic [7:0] d);
      wr_t w;
      w.ch   = c;
      w.data = d;
      expWr.push_back(w);
   endtask

   // Present a word and hold it until the DUT takes it (busy low at the edge)
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      int waited;
      waited    = 0;
      pkt_valid = v;
      data_in   = d;
      @(negedge clock);
      while (busyX && waited < 300) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("accept_wait", 32'(busyX), 0);
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      pkt_valid = 1'b0;
      data_in   = 8'($urandom);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Send header, the words in pay, then a check word; chkSel 0 = XOR, 1 = CRC, 2 = chkVal
   task automatic sendPacket(input logic [7:0] hdr, input int chkSel, input logic [7:0] chkVal,
                             input int bpIndex);
      logic [1:0] addr;
      logic [5:0] lenf;
      logic [7:0] xr, cr, chk;
      logic       good;
      stat_t      st;
      addr = hdr[1:0];
      lenf = hdr[7:2];
      good = (addr != 2'd3);
      xr   = hdr;
      cr   = crcByte(8'h00, hdr);
      foreach (pay[i]) begin
         xr = xr ^ pay[i];
         cr = crcByte(cr, pay[i]);
      end
      chk = (chkSel == 0) ? xr : ((chkSel == 1) ? cr : chkVal);
      if (good) expectWord(addr, hdr);
      else addrErrSent++;
      applyStimulus(1'b1, hdr);
      for (int i = 0; i < pay.size(); i++) begin
         if (good) expectWord(addr, pay[i]);
         if (i == bpIndex) forcedFull = 3'b001 << addr;
         applyStimulus(1'b1, pay[i]);
         if (i == bpIndex) begin
            if (i + 1 < pay.size()) data_in = pay[i+1];
            repeat (2) begin
               @(negedge clock);
               checkOutput("bp_busy_x", 32'(busyX), 1);
               checkOutput("bp_busy_c", 32'(busyC), 1);
            end
            @(negedge clock);
            forcedFull = 3'b000;
         end
      end
      if (good) begin
         expectWord(addr, chk);
         st.xperr = (xr != chk);
         st.cperr = (cr != chk);
         st.lerr  = (pay.size() != int'(lenf));
         statQ.push_back(st);
      end
      applyStimulus(1'b0, chk);
   endtask

   // Output monitor: FIFO writes, packet status and address errors against the model queues
   always @(negedge clock) begin
      if (reset) begin
         expErrX = 0;
         expErrC = 0;
      end else begin
         if (weX != 3'b000) begin
            checkOutput("we_onehot", 32'($onehot(weX)), 1);
            if (expWr.size() == 0) begin
               checkOutput("wr_unexpected", 32'(weX), 0);
            end else begin
               mw = expWr.pop_front();
               checkOutput("wr_ch_x", 32'(weX), 32'(1) << mw.ch);
               checkOutput("wr_data_x", 32'(doutX), 32'(mw.data));
               checkOutput("wr_ch_c", 32'(weC), 32'(1) << mw.ch);
               checkOutput("wr_data_c", 32'(doutC), 32'(mw.data));
            end
         end else begin
            checkOutput("we_idle_c", 32'(weC), 0);
         end
         if (doneX || doneC) begin
            if (statQ.size() == 0) begin
               checkOutput("done_unexpected", 32'({doneX, doneC}), 0);
            end else begin
               ms = statQ.pop_front();
               checkOutput("done_x", 32'(doneX), 1);
               checkOutput("done_c", 32'(doneC), 1);
               checkOutput("parity_x", 32'(perrX), 32'(ms.xperr));
               checkOutput("parity_c", 32'(perrC), 32'(ms.cperr));
               checkOutput("len_x", 32'(lerrX), 32'(ms.lerr));
               checkOutput("len_c", 32'(lerrC), 32'(ms.lerr));
               if ((ms.xperr || ms.lerr) && expErrX < 65535) expErrX++;
               if ((ms.cperr || ms.lerr) && expErrC < 65535) expErrC++;
               checkOutput("err_count_x", 32'(errCntX), 32'(expErrX));
               checkOutput("err_count_c", 32'(errCntC), 32'(expErrC));
            end
         end else begin
            checkOutput("status_idle", 32'({perrX, perrC, lerrX, lerrC}), 0);
         end
         if (aerrX || aerrC) begin
            checkOutput("addr_err_expected", 32'(addrErrSeen < addrErrSent), 1);
            addrErrSeen++;
            checkOutput("addr_err_x", 32'(aerrX), 1);
            checkOutput("addr_err_c", 32'(aerrC), 1);
            if (expErrX < 65535) expErrX++;
            if (expErrC < 65535) expErrC++;
            checkOutput("err_count_x", 32'(errCntX), 32'(expErrX));
            checkOutput("err_count_c", 32'(errCntC), 32'(expErrC));
         end
      end
   end

   initial begin
      logic [7:0] hdr;
      int         lenf, npay, r;
      checks      = 0;
      errors      = 0;
      addrErrSent = 0;
      addrErrSeen = 0;
      expErrX     = 0;
      expErrC     = 0;
      fullRandom  = 1'b0;
      forcedFull  = 3'b000;
      pkt_valid   = 1'b0;
      data_in     = 8'h00;
      reset       = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("rst_busy", 32'(busyX), 0);
      checkOutput("rst_we", 32'(weX), 0);
      checkOutput("rst_dout", 32'(doutX), 0);
      checkOutput("rst_status", 32'({doneX, perrX, lerrX, aerrX}), 0);
      checkOutput("rst_err_count", 32'(errCntX), 0);
      @(posedge clock);
      #1 reset = 1'b0;
      idleCycles(2);

      // Good packet, then the same packet with a corrupted check word
      pay = {8'h11, 8'h22, 8'h33};
      sendPacket(8'h0D, 2, 8'h0D, -1);
      idleCycles(1);
      sendPacket(8'h0D, 2, 8'h0C, -1);
      idleCycles(1);
      // Backpressure on channel 1 while 22 is offered
      sendPacket(8'h0D, 0, 8'h00, 1);
      idleCycles(1);
      // Invalid destination is dropped, the following packet is unaffected
      pay = {8'hAA, 8'hBB};
      sendPacket(8'h07, 2, 8'h55, -1);
      pay = {8'h11, 8'h22, 8'h33};
      sendPacket(8'h0D, 0, 8'h00, -1);
      // Header claims two payload words but three arrive
      sendPacket(8'h09, 0, 8'h00, -1);
      // Correct CRC check word
      sendPacket(8'h0D, 1, 8'h00, -1);
      // Empty packet, then payload count at and beyond the length field maximum
      pay.delete();
      sendPacket(8'h00, 0, 8'h00, -1);
      for (int k = 0; k < 63; k++) pay.push_back(8'($urandom));
      sendPacket(8'hFD, 0, 8'h00, -1);
      pay.push_back(8'($urandom));
      sendPacket(8'hFE, 1, 8'h00, -1);
      idleCycles(2);

      // Random packets under random backpressure
      fullRandom = 1'b1;
      for (int n = 0; n < 150; n++) begin
         lenf = $urandom_range(0, 6);
         hdr  = {6'(lenf), 2'($urandom_range(0, 3))};
         npay = lenf;
         r    = $urandom_range(0, 5);
         if (r == 0) npay = lenf + 1;
         else if (r == 1 && lenf > 0) npay = lenf - 1;
         pay.delete();
         for (int k = 0; k < npay; k++) pay.push_back(8'($urandom));
         sendPacket(hdr, $urandom_range(0, 2), 8'($urandom), -1);
         idleCycles($urandom_range(0, 2));
      end
      fullRandom = 1'b0;
      idleCycles(20);
      checkOutput("drain_writes", 32'(expWr.size()), 0);

      // Reset with a word waiting in the hold register
      expectWord(2'd1, 8'h0D);
      applyStimulus(1'b1, 8'h0D);
      expectWord(2'd1, 8'h11);
      applyStimulus(1'b1, 8'h11);
      forcedFull = 3'b010;
      expectWord(2'd1, 8'h22);
      applyStimulus(1'b1, 8'h22);
      @(negedge clock);
      checkOutput("pre_rst_pending", 32'(expWr.size()), 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", 32'(busyX), 0);
      checkOutput("mid_rst_we", 32'(weX), 0);
      checkOutput("mid_rst_dout", 32'(doutX), 0);
      checkOutput("mid_rst_status", 32'({doneX, perrX, lerrX, aerrX}), 0);
      checkOutput("mid_rst_err_count", 32'(errCntX), 0);
      expWr.delete();
      forcedFull = 3'b000;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      idleCycles(3);
      pay = {8'h11, 8'h22, 8'h33};
      sendPacket(8'h0D, 2, 8'h0D, -1);
      idleCycles(5);

      checkOutput("final_writes", 32'(expWr.size()), 0);
      checkOutput("final_status", 32'(statQ.size()), 0);
      checkOutput("final_addr_err", 32'(addrErrSeen), 32'(addrErrSent));
      checkOutput("final_err_x", 32'(errCntX), 32'(expErrX));
      checkOutput("final_err_c", 32'(errCntC), 32'(expErrC));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
